// File: rtl/surge_pkg.sv
// Shared types for the slot-bitmap scanners: enumeration order and scan FSM state.
package surge_pkg;

    typedef enum logic {
        SCAN_LSB = 1'b0,
        SCAN_MSB = 1'b1
    } scan_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/ffs_scanner_if.sv
// Job / index-beat bundle between a bitmap owner, the scanner and an index consumer.
interface ffs_scanner_if #(
    parameter int WIDTH_LOG = 6
);
    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam int CNT_W = WIDTH_LOG + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_bitmap;
    logic                 in_msb_first;
    logic [CNT_W-1:0]     in_max_count;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH_LOG-1:0] out_index;
    logic [CNT_W-1:0]     out_seq;
    logic                 out_last;
    logic                 out_zero;
    logic                 busy;

    modport master (
        output in_valid, in_bitmap, in_msb_first, in_max_count, flush, out_ready,
        input  in_ready, out_valid, out_index, out_seq, out_last, out_zero, busy
    );

    modport slave (
        input  in_valid, in_bitmap, in_msb_first, in_max_count, flush, out_ready,
        output in_ready, out_valid, out_index, out_seq, out_last, out_zero, busy
    );

endinterface

// File: rtl/ffs_scanner_prio.sv
// Purpose: combinational highest/lowest set-bit finder. Latency: 0 cycles.
// Backpressure: none (pure combinational).
module ffs_prio #(
    parameter int WIDTH_LOG = 6
) (
    input  logic [(1<<WIDTH_LOG)-1:0] i_vec,
    output logic [WIDTH_LOG-1:0]      o_msb,
    output logic [WIDTH_LOG-1:0]      o_lsb,
    output logic                      o_zero
);
    localparam int WIDTH = 1 << WIDTH_LOG;

    // Opposite scan directions so the last hit wins: lowest for lsb, highest for msb.
    always_comb begin
        o_lsb = '0;
        o_msb = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) o_lsb = WIDTH_LOG'(i);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) o_msb = WIDTH_LOG'(i);
        end
        o_zero = ~|i_vec;
    end

endmodule

// File: rtl/ffs_scanner.sv
// Purpose: streams set-bit indices of a bitmap job. Latency: first beat 1 cycle after accept, then 1/cycle.
// Backpressure: out_ready low holds the beat registers; in_ready only while idle.
module ffs_scanner
    import surge_pkg::*;
#(
    parameter int WIDTH_LOG = 6
) (
    input  logic          clk,
    input  logic          rst,
    ffs_scanner_if.slave  bus
);
    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam int CNT_W = WIDTH_LOG + 1;

    scan_state_e          r_state;
    scan_mode_e           r_mode;
    logic [CNT_W-1:0]     r_limit;
    logic [WIDTH-1:0]     r_residual;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [WIDTH_LOG-1:0] r_out_index;
    logic [CNT_W-1:0]     r_out_seq;
    logic                 r_out_last;
    logic                 r_out_zero;

    logic                 w_idle;
    logic                 w_accept;
    logic                 w_fire;
    logic                 w_msb_sel;
    logic [WIDTH-1:0]     w_prio_in;
    logic [WIDTH_LOG-1:0] w_msb;
    logic [WIDTH_LOG-1:0] w_lsb;
    logic                 w_zero;
    logic [WIDTH_LOG-1:0] w_idx;
    logic [WIDTH-1:0]     w_cleared;
    logic [CNT_W-1:0]     w_seq_nxt;
    logic [CNT_W-1:0]     w_lim;
    logic                 w_last_nxt;

    // One finder serves both the first beat (fresh bitmap) and every later beat (residual).
    assign w_idle    = (r_state == IDLE);
    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_fire    = r_out_valid & bus.out_ready;
    assign w_msb_sel = w_idle ? bus.in_msb_first : (r_mode == SCAN_MSB);
    assign w_prio_in = w_idle ? bus.in_bitmap : r_residual;
    assign w_lim     = w_idle ? bus.in_max_count : r_limit;
    assign w_seq_nxt = w_idle ? '0 : r_out_seq + CNT_W'(1);

    ffs_prio #(.WIDTH_LOG(WIDTH_LOG)) u_prio (
        .i_vec  (w_prio_in),
        .o_msb  (w_msb),
        .o_lsb  (w_lsb),
        .o_zero (w_zero)
    );

    assign w_idx      = w_msb_sel ? w_msb : w_lsb;
    assign w_cleared  = w_prio_in & ~(WIDTH'(1) << w_idx);
    // Limits above WIDTH are never reached, so they fall through as unlimited.
    assign w_last_nxt = (w_cleared == '0) ||
                        ((w_lim != '0) && ((w_seq_nxt + CNT_W'(1)) == w_lim));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= SCAN_LSB;
            r_limit     <= '0;
            r_residual  <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_seq   <= '0;
            r_out_last  <= 1'b0;
            r_out_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_state     <= SCAN;
                        r_in_ready  <= 1'b0;
                        r_mode      <= bus.in_msb_first ? SCAN_MSB : SCAN_LSB;
                        r_limit     <= bus.in_max_count;
                        r_residual  <= w_cleared;
                        r_out_valid <= 1'b1;
                        r_out_index <= w_idx;
                        r_out_seq   <= '0;
                        r_out_last  <= w_last_nxt;
                        r_out_zero  <= w_zero;
                    end
                end
                SCAN: begin
                    if (bus.flush || (w_fire && r_out_last)) begin
                        r_state     <= IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_residual  <= '0;
                    end else if (w_fire) begin
                        r_residual  <= w_cleared;
                        r_out_index <= w_idx;
                        r_out_seq   <= w_seq_nxt;
                        r_out_last  <= w_last_nxt;
                        r_out_zero  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_index = r_out_index;
    assign bus.out_seq   = r_out_seq;
    assign bus.out_last  = r_out_last;
    assign bus.out_zero  = r_out_zero;
    assign bus.busy      = (r_state == SCAN);

endmodule

// File: tb/tb_ffs_scanner.sv
// Randomised bench for ffs_scanner against a list-based model of the expected index stream.
module tb_ffs_scanner;

    typedef struct {
        logic [5:0] idx;
        logic [6:0] seq;
        logic       last;
        logic       zero;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    ffs_scanner_if #(.WIDTH_LOG(6)) bus ();

    ffs_scanner #(.WIDTH_LOG(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: list every set bit in the requested order, then trim to the limit.
    function automatic void build_model(input logic [63:0] bm, input logic msb,
                                        input logic [6:0] lim, output beat_t q[$]);
        int idxs[$];
        int n;
        beat_t b;
        q = {};
        for (int k = 0; k < 64; k++) begin
            int pos = msb ? 63 - k : k;
            if (bm[pos]) idxs.push_back(pos);
        end
        if (idxs.size() == 0) begin
            b.idx = 6'd0; b.seq = 7'd0; b.last = 1'b1; b.zero = 1'b1;
            q.push_back(b);
            return;
        end
        n = idxs.size();
        if (lim != 0 && int'(lim) < n) n = int'(lim);
        for (int k = 0; k < n; k++) begin
            b.idx = 6'(idxs[k]); b.seq = 7'(k); b.last = (k == n - 1); b.zero = 1'b0;
            q.push_back(b);
        end
    endfunction

    task automatic start_job(input logic [63:0] bm, input logic msb, input logic [6:0] lim);
        int cnt = 0;
        while (bus.in_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid     = 1'b1;
        bus.in_bitmap    = bm;
        bus.in_msb_first = msb;
        bus.in_max_count = lim;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_job(input string name, input logic [63:0] bm, input logic msb,
                           input logic [6:0] lim, input int rdy_pct);
        beat_t exp[$];
        int cycles = 0;
        int n_beats;
        build_model(bm, msb, lim, exp);
        n_beats = exp.size();
        start_job(bm, msb, lim);
        while (exp.size() > 0 && cycles < 2000) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_index !== exp[0].idx || bus.out_seq !== exp[0].seq ||
                bus.out_last !== exp[0].last || bus.out_zero !== exp[0].zero) begin
                n_err++;
                $display("FAIL %s beat: v=%b idx=%0d seq=%0d last=%b zero=%b required v=1 idx=%0d seq=%0d last=%b zero=%b",
                         name, bus.out_valid, bus.out_index, bus.out_seq, bus.out_last, bus.out_zero,
                         exp[0].idx, exp[0].seq, exp[0].last, exp[0].zero);
            end
            n_cmp++;
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s busy_in_scan: busy=%b in_ready=%b required 1/0", name, bus.busy, bus.in_ready);
            end
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (bus.out_ready) void'(exp.pop_front());
            cycles++;
        end
        bus.out_ready = 1'b0;
        if (rdy_pct >= 100) begin
            n_cmp++;
            if (cycles != n_beats) begin
                n_err++;
                $display("FAIL %s beat_rate: cycles=%0d required %0d", name, cycles, n_beats);
            end
        end
        n_cmp++;
        if (exp.size() != 0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s end_of_job: left=%0d v=%b busy=%b in_ready=%b required 0/0/0/1",
                     name, exp.size(), bus.out_valid, bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_index !== 6'd0 || bus.out_seq !== 7'd0 ||
            bus.out_last !== 1'b0 || bus.out_zero !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: v=%b idx=%0d seq=%0d last=%b zero=%b busy=%b required all 0",
                     bus.out_valid, bus.out_index, bus.out_seq, bus.out_last, bus.out_zero, bus.busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b busy=%b v=%b required 1/0/0",
                     bus.in_ready, bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        run_job("lsb_sparse", 64'h8000_0000_0000_0011, 1'b0, 7'd0, 100);
        run_job("msb_sparse", 64'h8000_0000_0000_0011, 1'b1, 7'd0, 100);
        run_job("zero_map", 64'h0, 1'b0, 7'd0, 100);
        run_job("ones_lim3", {64{1'b1}}, 1'b0, 7'd3, 100);
        run_job("ones_unlim", {64{1'b1}}, 1'b0, 7'd0, 100);
        run_job("ones_msb_lim100", {64{1'b1}}, 1'b1, 7'd100, 100);
        run_job("lim1", 64'h0000_0100_0000_0000, 1'b1, 7'd1, 100);
    endtask

    task automatic test_stall();
        run_job("stall_f0f0", 64'hF0F0, 1'b0, 7'd0, 50);
        run_job("stall_f0f0_msb", 64'hF0F0, 1'b1, 7'd0, 30);
    endtask

    task automatic test_flush();
        start_job(64'hFF, 1'b0, 7'd0);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.out_index !== 6'd2 || bus.out_seq !== 7'd2) begin
            n_err++;
            $display("FAIL flush_pre: idx=%0d seq=%0d required 2/2", bus.out_index, bus.out_seq);
        end
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_scan: v=%b busy=%b in_ready=%b required 0/0/1",
                     bus.out_valid, bus.busy, bus.in_ready);
        end
        // flush while idle must not block an accept in the same cycle
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bitmap = 64'h5;
        bus.in_msb_first = 1'b0;
        bus.in_max_count = 7'd0;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_index !== 6'd0) begin
            n_err++;
            $display("FAIL flush_idle: busy=%b v=%b idx=%0d required 1/1/0", bus.busy, bus.out_valid, bus.out_index);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.out_index !== 6'd2 || bus.out_last !== 1'b1) begin
            n_err++;
            $display("FAIL flush_idle_2nd: idx=%0d last=%b required 2/1", bus.out_index, bus.out_last);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle_end: busy=%b v=%b required 0/0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_async_rst();
        start_job(64'hFF00, 1'b1, 7'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_seq !== 7'd0) begin
            n_err++;
            $display("FAIL async_rst: v=%b busy=%b seq=%0d required 0/0/0", bus.out_valid, bus.busy, bus.out_seq);
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst_release: in_ready=%b busy=%b required 1/0", bus.in_ready, bus.busy);
        end
        run_job("after_rst", 64'h8000_0000_0000_0011, 1'b1, 7'd2, 100);
    endtask

    task automatic test_random();
        for (int j = 0; j < 25; j++) begin
            logic [63:0] bm;
            bm = {$urandom(), $urandom()};
            case ($urandom_range(3))
                0: bm = bm & {$urandom(), $urandom()} & {$urandom(), $urandom()};
                1: bm = 64'(1) << $urandom_range(63);
                default: ;
            endcase
            run_job("random", bm, 1'($urandom_range(1)), 7'($urandom_range(70)), 40 + $urandom_range(60));
        end
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_bitmap    = '0;
        bus.in_msb_first = 1'b0;
        bus.in_max_count = '0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_flush();
        test_async_rst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
